// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core parameters
package riscv_pkg;
  localparam int REGISTER_PORTS = 2;
endpackage

// File: rtl/riscv_regfile_if.sv
// riscv_regfile_if: lock/writeback request bus and architectural register state
interface riscv_regfile_if #(parameter int PORTS = riscv_pkg::REGISTER_PORTS);
  logic [PORTS-1:0]             register_lock_en;
  logic [PORTS-1:0][4:0]        register_lock;
  logic [PORTS-1:0]             register_write_en;
  logic [PORTS-1:0][4:0]        register_write;
  logic [PORTS-1:0][31:0]       register_write_data;
  logic [31:0][31:0]            register;
  logic [31:0]                  register_locked;
  logic [5:0]                   locked_count;
  logic                         err_write_conflict;
  logic                         err_write_unlocked;
  modport master (
    output register_lock_en, register_lock, register_write_en, register_write, register_write_data,
    input  register, register_locked, locked_count, err_write_conflict, err_write_unlocked
  );
  modport slave (
    input  register_lock_en, register_lock, register_write_en, register_write, register_write_data,
    output register, register_locked, locked_count, err_write_conflict, err_write_unlocked
  );
endinterface

// File: rtl/riscv_regfile.sv
// riscv_regfile: 32x32 register file with per-register pending-writeback lock bits
module riscv_regfile #(
  parameter int PORTS = riscv_pkg::REGISTER_PORTS
) (
  input logic clock,
  input logic reset,
  riscv_regfile_if.slave bus
);
  logic [31:0][31:0] regs_n;
  logic [31:0]       lock_n;
  logic [5:0]        cnt_n;
  logic              conflict, unlocked;
  // writes clear lock bits before locks set them, so a same-cycle lock wins
  always_comb begin
    regs_n = bus.register;
    lock_n = bus.register_locked;
    conflict = 1'b0;
    unlocked = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      if (bus.register_write_en[p] && bus.register_write[p] != 5'd0) begin
        regs_n[bus.register_write[p]] = bus.register_write_data[p];
        lock_n[bus.register_write[p]] = 1'b0;
        unlocked = unlocked | ~bus.register_locked[bus.register_write[p]];
        for (int q = 0; q < p; q++)
          conflict = conflict | (bus.register_write_en[q] && bus.register_write[q] == bus.register_write[p]);
      end
    end
    for (int p = 0; p < PORTS; p++)
      if (bus.register_lock_en[p] && bus.register_lock[p] != 5'd0)
        lock_n[bus.register_lock[p]] = 1'b1;
    regs_n[0] = 32'd0;
    lock_n[0] = 1'b0;
    cnt_n = 6'd0;
    for (int i = 1; i < 32; i++)
      cnt_n = cnt_n + 6'(lock_n[i]);
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      bus.register <= '0;
      bus.register_locked <= '0;
      bus.locked_count <= '0;
      bus.err_write_conflict <= 1'b0;
      bus.err_write_unlocked <= 1'b0;
    end else begin
      bus.register <= regs_n;
      bus.register_locked <= lock_n;
      bus.locked_count <= cnt_n;
      bus.err_write_conflict <= bus.err_write_conflict | conflict;
      bus.err_write_unlocked <= bus.err_write_unlocked | unlocked;
    end
  end
endmodule
